eq_gain_regfile: RTL and testbench

- Parametrised, double-buffered successor of the equaliser gain register bank.
- Byte-wide host bus writes per-band gain bytes into a shadow bank.
- A commit request copies all shadow gains into the active bank atomically on the next audio `sample_tick`, so the filter datapath never sees a half-updated gain.
- Adds readback, a status register, error flagging and an auto-incrementing pointer/data port for burst loads.

---
 rtl/eq_regmap_pkg.sv | 39 +++
 rtl/eq_gain_regfile_if.sv | 21 ++
 rtl/eq_gain_regfile_commit_ctrl.sv | 45 ++++
 rtl/eq_gain_regfile.sv | 152 +++++++++++++++
 tb/tb_eq_gain_regfile.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/eq_regmap_pkg.sv
// Register map, bit positions and commit FSM encoding shared by the
// equaliser gain register file and its commit controller.
package eq_regmap_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int STATUS_PEND_BIT = 0;
  localparam int STATUS_ERR_BIT  = 1;

  function automatic int gain_bytes(input int gain_width);
    return (gain_width + 7) / 8;
  endfunction

  function automatic int ctrl_addr();
    return 0;
  endfunction

  // Band k, byte j (LSB byte first) of the shadow bank.
  function automatic int gain_addr(input int k, input int j, input int gb);
    return 1 + k * gb + j;
  endfunction

  function automatic int status_addr(input int n_bands, input int gb);
    return n_bands * gb + 1;
  endfunction

  function automatic int ptr_addr(input int n_bands, input int gb);
    return n_bands * gb + 2;
  endfunction

  function automatic int data_addr(input int n_bands, input int gb);
    return n_bands * gb + 3;
  endfunction

endpackage

// File: rtl/eq_gain_regfile_if.sv
// Byte-wide host bus of the equaliser gain register file.
interface eq_gain_regfile_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            data_in;
  logic [7:0]            data_out;
  logic                  rd_valid;

  modport master (
    output we, re, addr, data_in,
    input  data_out, rd_valid
  );

  modport slave (
    input  we, re, addr, data_in,
    output data_out, rd_valid
  );
endinterface

// File: rtl/eq_gain_regfile_commit_ctrl.sv
// Commit FSM: holds a requested commit until the next sample tick, then
// fires the shadow-to-active copy and a one-cycle gain_update pulse.
module eq_commit_ctrl
  import eq_regmap_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic commit_req,
  input  logic sample_tick,
  output logic apply,
  output logic commit_pending,
  output logic gain_update
);

  commit_state_e state_q, state_d;
  logic          gain_update_q, gain_update_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      gain_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gain_update_q <= gain_update_d;
    end
  end

  // A tick in the same cycle as the commit write is seen while still IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (commit_req)  state_d = ST_PENDING;
      ST_PENDING: if (sample_tick) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    apply          = (state_q == ST_PENDING) && sample_tick;
    commit_pending = (state_q == ST_PENDING);
    gain_update_d  = apply;
    gain_update    = gain_update_q;
  end

endmodule

// File: rtl/eq_gain_regfile.sv
// Double-buffered equaliser gain register file: host writes a shadow bank,
// a commit copies it atomically into the active bank on the next sample tick.
module eq_gain_regfile
  import eq_regmap_pkg::*;
#(
  parameter int N_BANDS    = 10,
  parameter int GAIN_WIDTH = 24,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  eq_gain_regfile_if.slave                bus,
  input  logic                            sample_tick,
  output logic [7:0]                      configuration,
  output logic [N_BANDS*GAIN_WIDTH-1:0]   gains,
  output logic                            commit_pending,
  output logic                            gain_update
);

  localparam int GB    = gain_bytes(GAIN_WIDTH);
  localparam int L     = N_BANDS * GB;
  localparam int IDX_W = (L > 1) ? $clog2(L) : 1;

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(ctrl_addr());
  localparam logic [ADDR_WIDTH-1:0] A_GAIN0  = ADDR_WIDTH'(gain_addr(0, 0, GB));
  localparam logic [ADDR_WIDTH-1:0] A_GAINL  = ADDR_WIDTH'(gain_addr(N_BANDS - 1, GB - 1, GB));
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(status_addr(N_BANDS, GB));
  localparam logic [ADDR_WIDTH-1:0] A_PTR    = ADDR_WIDTH'(ptr_addr(N_BANDS, GB));
  localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(data_addr(N_BANDS, GB));

  if (N_BANDS * GB + 3 >= 2 ** ADDR_WIDTH) begin : g_bad_params
    $error("eq_gain_regfile: register map does not fit in ADDR_WIDTH");
  end

  logic [7:0]       shadow_q [L];
  logic [7:0]       shadow_d [L];
  logic [7:0]       active_q [L];
  logic [7:0]       active_d [L];
  logic [7:1]       ctrl_q, ctrl_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_ctrl, is_gain, is_status, is_ptr, is_data, is_bad;
  logic                  access, ptr_wr_bad;
  logic [IDX_W-1:0]      gidx, ptr_inc;
  logic [7:0]            rd_byte, status_byte;
  logic                  commit_req, apply;

  assign addr      = bus.addr;
  assign is_ctrl   = (addr == A_CTRL);
  assign is_gain   = (addr >= A_GAIN0) && (addr <= A_GAINL);
  assign is_status = (addr == A_STATUS);
  assign is_ptr    = (addr == A_PTR);
  assign is_data   = (addr == A_DATA);
  assign is_bad    = (addr > A_DATA);
  assign access    = bus.we || bus.re;
  assign gidx      = IDX_W'(addr - A_GAIN0);
  assign ptr_wr_bad = (int'(bus.data_in) >= L);
  assign ptr_inc   = (ptr_q == IDX_W'(L - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    status_byte                  = '0;
    status_byte[STATUS_PEND_BIT] = commit_pending;
    status_byte[STATUS_ERR_BIT]  = err_q;
  end

  // Reads see pre-write state, so a simultaneous write is invisible here.
  always_comb begin
    rd_byte = 8'h00;
    if (is_ctrl)        rd_byte = {ctrl_q, 1'b0};
    else if (is_gain)   rd_byte = shadow_q[gidx];
    else if (is_status) rd_byte = status_byte;
    else if (is_ptr)    rd_byte = 8'(ptr_q);
    else if (is_data)   rd_byte = shadow_q[ptr_q];
  end

  always_comb begin
    shadow_d   = shadow_q;
    ctrl_d     = ctrl_q;
    ptr_d      = ptr_q;
    err_d      = err_q;
    commit_req = 1'b0;
    if (bus.we) begin
      if (is_ctrl) begin
        ctrl_d     = bus.data_in[7:1];
        commit_req = bus.data_in[CTRL_COMMIT_BIT];
      end
      if (is_gain) shadow_d[gidx] = bus.data_in;
      if (is_status && bus.data_in[STATUS_ERR_BIT]) err_d = 1'b0;
      if (is_ptr) begin
        if (ptr_wr_bad) err_d = 1'b1;
        else            ptr_d = IDX_W'(bus.data_in);
      end
      if (is_data) shadow_d[ptr_q] = bus.data_in;
    end
    // One increment per DATA access, even when read and write coincide.
    if (access && is_data) ptr_d = ptr_inc;
    if (access && is_bad)  err_d = 1'b1;
  end

  always_comb begin
    active_d   = apply ? shadow_q : active_q;
    data_out_d = bus.re ? rd_byte : data_out_q;
    rd_valid_d = bus.re;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      ctrl_q     <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      ctrl_q     <= ctrl_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  eq_commit_ctrl u_commit (
    .clk            (clk),
    .rst            (rst),
    .commit_req     (commit_req),
    .sample_tick    (sample_tick),
    .apply          (apply),
    .commit_pending (commit_pending),
    .gain_update    (gain_update)
  );

  for (genvar k = 0; k < N_BANDS; k++) begin : g_band
    logic [GB*8-1:0] word;
    for (genvar j = 0; j < GB; j++) begin : g_byte
      assign word[j*8 +: 8] = active_q[gain_addr(k, j, GB) - 1];
    end
    assign gains[k*GAIN_WIDTH +: GAIN_WIDTH] = word[GAIN_WIDTH-1:0];
  end

  assign bus.data_out  = data_out_q;
  assign bus.rd_valid  = rd_valid_q;
  assign configuration = {ctrl_q, 1'b0};

endmodule

// File: tb/tb_eq_gain_regfile.sv
// Directed bench for eq_gain_regfile with default parameters (L = 30,
// STATUS = 31, PTR = 32, DATA = 33).
module tb_eq_gain_regfile;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_tick;
  logic [7:0]   configuration;
  logic [239:0] gains;
  logic         commit_pending;
  logic         gain_update;

  int n_cmp = 0;
  int n_bad = 0;

  eq_gain_regfile_if #(.ADDR_WIDTH(8)) bus ();

  eq_gain_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .sample_tick    (sample_tick),
    .configuration  (configuration),
    .gains          (gains),
    .commit_pending (commit_pending),
    .gain_update    (gain_update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.we = 1'b1; bus.addr = a; bus.data_in = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    bus.re = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.re = 1'b0;
    chk({tag, "_vld"}, bus.rd_valid, 1);
    chk(tag, bus.data_out, exp);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b0;
    bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_gains", gains, 0);
    chk("rst_pend", commit_pending, 0);
    chk("rst_upd", gain_update, 0);
    chk("rst_vld", bus.rd_valid, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_cfg", configuration, 0);
    rd(8'd0, 8'h00, "rd_ctrl0");
    rd(8'd1, 8'h00, "rd_gain0");
    rd(8'd31, 8'h00, "rd_stat0");
    @(negedge clk);
    chk("vld_pulse", bus.rd_valid, 0);
    chk("dout_hold", bus.data_out, 0);

    // Basic commit, applied on a tick five cycles later
    wr(8'd1, 8'h56); wr(8'd2, 8'h34); wr(8'd3, 8'h12);
    wr(8'd0, 8'h01);
    chk("cm_pend", commit_pending, 1);
    repeat (4) @(negedge clk);
    chk("cm_wait", gains[23:0], 0);
    chk("cm_wait_upd", gain_update, 0);
    tick();
    chk("cm_gain", gains[23:0], 24'h123456);
    chk("cm_upd", gain_update, 1);
    chk("cm_pend_drop", commit_pending, 0);
    @(negedge clk);
    chk("cm_upd_once", gain_update, 0);
    wr(8'd0, 8'hA4);
    chk("cfg", configuration, 8'hA4);
    rd(8'd0, 8'hA4, "rd_ctrl");
    chk("cfg_no_pend", commit_pending, 0);

    // Burst via PTR/DATA with wrap
    wr(8'd32, 8'd0);
    for (int i = 0; i < 30; i++) wr(8'd33, 8'(8'h80 + i));
    wr(8'd33, 8'hEE);
    rd(8'd32, 8'd1, "ptr_wrap");
    rd(8'd1, 8'hEE, "burst_b1");
    rd(8'd2, 8'h81, "burst_b2");
    rd(8'd30, 8'h9D, "burst_b30");
    rd(8'd33, 8'h81, "data_rd");

    // COMMIT together with a tick: only the later tick applies
    bus.we = 1'b1; bus.addr = 8'd0; bus.data_in = 8'h01; sample_tick = 1'b1;
    @(negedge clk);
    bus.we = 1'b0; sample_tick = 1'b0;
    chk("st_pend", commit_pending, 1);
    chk("st_gain_old", gains[23:0], 24'h123456);
    chk("st_no_upd", gain_update, 0);
    repeat (2) @(negedge clk);
    tick();
    chk("st_gain_b0", gains[23:0], 24'h8281EE);
    chk("st_gain_b1", gains[47:24], 24'h858483);
    chk("st_gain_b9", gains[239:216], 24'h9D9C9B);
    chk("st_upd", gain_update, 1);
    chk("st_cfg", configuration, 8'h00);

    // Error flagging and clearing
    wr(8'd34, 8'hFF);
    rd(8'd31, 8'h02, "err_set");
    rd(8'd32, 8'd2, "err_ptr_keep");
    wr(8'd31, 8'h02);
    rd(8'd31, 8'h00, "err_clr");
    wr(8'd32, 8'd30);
    rd(8'd31, 8'h02, "ptr_bad_err");
    rd(8'd32, 8'd2, "ptr_bad_keep");
    rd(8'd34, 8'h00, "bad_rd");
    wr(8'd31, 8'h02);

    // Simultaneous write and read
    bus.we = 1'b1; bus.re = 1'b1; bus.addr = 8'd1; bus.data_in = 8'h11;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    chk("wr_rd_old", bus.data_out, 8'hEE);
    rd(8'd1, 8'h11, "wr_rd_new");
    bus.we = 1'b1; bus.re = 1'b1; bus.addr = 8'd33; bus.data_in = 8'h55;
    @(negedge clk);
    bus.we = 1'b0; bus.re = 1'b0;
    chk("data_wr_rd_old", bus.data_out, 8'h82);
    rd(8'd3, 8'h55, "data_wr_rd_new");
    rd(8'd32, 8'd3, "data_wr_rd_ptr");

    // Reset discards a pending commit
    wr(8'd0, 8'h01);
    chk("rs_pend", commit_pending, 1);
    rst = 1'b1;
    #1;
    chk("rs_pend_drop", commit_pending, 0);
    chk("rs_gains", gains, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rs_tick_gains", gains, 0);
    chk("rs_tick_upd", gain_update, 0);
    rd(8'd1, 8'h00, "rs_shadow");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
